// File: rtl/cla_seq_adder_ctrl_if.sv
// Operand/result handshake bundle for the sequential carry-lookahead adder.
// The master side is the operand source and result consumer; the slave side is the adder.
interface cla_seq_adder_ctrl_if #(
    parameter int unsigned W = 32
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/cla_seq_adder_ctrl.sv
// Multi-cycle W-bit adder: one shared N-bit carry-lookahead slice processes one chunk per
// cycle (LSB first) with a registered ripple carry; results leave over a valid/ready port.
module cla_seq_adder_ctrl #(
    parameter int unsigned W = 32,
    parameter int unsigned N = 4
) (
    input logic                 clk,
    input logic                 rst,
    cla_seq_adder_ctrl_if.slave bus
);

    localparam int unsigned CHUNKS = W / N;
    localparam int unsigned CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    generate
        if ((W % N) != 0) begin : g_bad_width
            $error("cla_seq_adder_ctrl: W must be a multiple of N");
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic          accept;
    logic          last;

    // Slice signals: operands are shifted down so the active chunk is always at [N-1:0].
    logic [N-1:0]  sl_a, sl_b, sl_p, sl_g, sl_sum;
    logic [N:0]    sl_c;
    logic          term;

    assign accept = (state_q == StIdle) && bus.in_valid;
    assign last   = (cnt_q == CW'(CHUNKS - 1));

    // Full lookahead: each carry is a flat sum of generate terms propagated through p.
    always_comb begin
        sl_a = a_q[N-1:0];
        sl_b = b_q[N-1:0];
        sl_p = sl_a ^ sl_b;
        sl_g = sl_a & sl_b;
        sl_c = '0;
        term = 1'b0;
        sl_c[0] = carry_q;
        for (int i = 0; i < N; i++) begin
            term = carry_q;
            for (int k = 0; k <= i; k++) begin
                term = term & sl_p[k];
            end
            sl_c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = sl_g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & sl_p[k];
                end
                sl_c[i+1] = sl_c[i+1] | term;
            end
        end
        sl_sum = sl_p ^ sl_c[N-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.in_valid) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next state; the sum register fills from the top so chunk 0 lands at bit 0.
    always_comb begin
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_d     = bus.a;
            b_d     = bus.b;
            carry_d = bus.cin;
            cnt_d   = '0;
        end else if (state_q == StRun) begin
            a_d     = a_q >> N;
            b_d     = b_q >> N;
            sum_d   = (sum_q >> N) | (W'(sl_sum) << (W - N));
            carry_d = sl_c[N];
            if (last) begin
                cout_d = sl_c[N];
                ovf_d  = sl_c[N-1] ^ sl_c[N];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
        bus.busy      = (state_q != StIdle);
        bus.sum       = sum_q;
        bus.cout      = cout_q;
        bus.ovf       = ovf_q;
    end

    a_no_ready_and_valid: assert property (@(posedge clk) disable iff (rst)
        !(bus.in_ready && bus.out_valid));

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Directed bench for cla_seq_adder_ctrl (W=32, N=4): reset, carry chain, overflow,
// backpressure, reset mid-operation, back-to-back throughput and a short random soak.
module tb_cla_seq_adder_ctrl;

    localparam int W = 32;
    localparam int N_RAND = 300;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    cla_seq_adder_ctrl_if #(.W(W)) bus ();

    cla_seq_adder_ctrl #(.W(W), .N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {ovf, cout, sum} from plain integer addition and sign rules.
    function automatic logic [33:0] golden(input logic [31:0] a, input logic [31:0] b,
                                           input logic cin);
        logic [32:0] t;
        logic        o;
        t = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        o = (a[31] == b[31]) && (t[31] != a[31]);
        return {o, t};
    endfunction

    // Issues one operation and waits for out_valid, leaving the result pending.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          output int lat);
        int guard;
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        lat = -1;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!bus.in_ready) begin
            bus.in_valid = 1'b0;
            return;
        end
        tick();
        bus.in_valid = 1'b0;
        guard = 0;
        while (!bus.out_valid && guard < 50) begin
            tick();
            guard++;
        end
        if (bus.out_valid) lat = guard;
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got rdy=%b vld=%b busy=%b want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.busy);
        end
        total++;
        if (bus.sum !== 32'h0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_data: got sum=%h cout=%b ovf=%b want 0 0 0",
                     bus.sum, bus.cout, bus.ovf);
        end
    endtask

    task automatic test_carry_chain();
        int lat;
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
        total++;
        if (lat !== 8) begin
            bad++;
            $display("FAIL carry_latency: got %0d want 8", lat);
        end
        total++;
        if (bus.sum !== 32'h0 || bus.cout !== 1'b1 || bus.ovf !== 1'b0) begin
            bad++;
            $display("FAIL carry_result: got sum=%h cout=%b ovf=%b want 00000000 1 0",
                     bus.sum, bus.cout, bus.ovf);
        end
        total++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL carry_done_flags: got rdy=%b busy=%b want 0 1",
                     bus.in_ready, bus.busy);
        end
        release_result();
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL carry_release: got rdy=%b vld=%b want 1 0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_overflow();
        int lat;
        run_op(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, lat);
        total++;
        if (bus.sum !== 32'h8000_0000 || bus.cout !== 1'b0 || bus.ovf !== 1'b1 || lat !== 8) begin
            bad++;
            $display("FAIL ovf_pos: got sum=%h cout=%b ovf=%b lat=%0d want 80000000 0 1 8",
                     bus.sum, bus.cout, bus.ovf, lat);
        end
        release_result();
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, lat);
        total++;
        if (bus.sum !== 32'h0 || bus.cout !== 1'b1 || bus.ovf !== 1'b1 || lat !== 8) begin
            bad++;
            $display("FAIL ovf_neg: got sum=%h cout=%b ovf=%b lat=%0d want 00000000 1 1 8",
                     bus.sum, bus.cout, bus.ovf, lat);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        int lat;
        int held_bad;
        run_op(32'h1111_1111, 32'h2222_2222, 1'b1, lat);
        held_bad = 0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.a = 32'h0000_0005;
            bus.b = 32'h0000_0007;
            bus.cin = 1'b0;
            tick();
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.sum !== 32'h3333_3334 ||
                bus.cout !== 1'b0 || bus.ovf !== 1'b0) held_bad++;
        end
        bus.in_valid = 1'b0;
        total++;
        if (held_bad != 0) begin
            bad++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0 (sum=%h vld=%b rdy=%b)",
                     held_bad, bus.sum, bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: got rdy=%b vld=%b busy=%b want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.busy);
        end
        tick();
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_no_ghost: got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bus.a = 32'h1234_5678;
        bus.b = 32'h9ABC_DEF0;
        bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.sum !== 32'h0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_run: got rdy=%b vld=%b busy=%b sum=%h cout=%b ovf=%b want 1 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.sum, bus.cout, bus.ovf);
        end
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, lat);
        total++;
        if (bus.sum !== 32'hACF1_3568 || bus.cout !== 1'b0 || bus.ovf !== 1'b0 || lat !== 8) begin
            bad++;
            $display("FAIL rst_reissue: got sum=%h cout=%b ovf=%b lat=%0d want ACF13568 0 0 8",
                     bus.sum, bus.cout, bus.ovf, lat);
        end
        // Reset wins over a simultaneous output handshake.
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.sum !== 32'h0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_in_done: got vld=%b sum=%h rdy=%b want 0 00000000 1",
                     bus.out_valid, bus.sum, bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic        vc [4];
        logic [33:0] exp;
        int acc_cyc [4];
        int nacc, nres, cyc;
        va = '{32'h0000_0001, 32'h0000_FFFF, 32'h8000_0000, 32'hDEAD_BEEF};
        vb = '{32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFF, 32'h1234_5678};
        vc = '{1'b0, 1'b0, 1'b1, 1'b1};
        nacc = 0;
        nres = 0;
        cyc = 0;
        bus.out_ready = 1'b1;
        bus.a = va[0];
        bus.b = vb[0];
        bus.cin = vc[0];
        bus.in_valid = 1'b1;
        while ((nacc < 4 || nres < 4) && cyc < 100) begin
            if (bus.out_valid) begin
                total++;
                if (nres >= 4) begin
                    bad++;
                    $display("FAIL b2b_extra: got result %0d want none", nres);
                end else begin
                    exp = golden(va[nres], vb[nres], vc[nres]);
                    if ({bus.ovf, bus.cout, bus.sum} !== exp) begin
                        bad++;
                        $display("FAIL b2b_result%0d: got %h want %h", nres,
                                 {bus.ovf, bus.cout, bus.sum}, exp);
                    end
                end
                nres++;
            end
            if (bus.in_valid && bus.in_ready) begin
                acc_cyc[nacc] = cyc;
                nacc++;
            end
            tick();
            cyc++;
            if (nacc < 4) begin
                bus.a = va[nacc];
                bus.b = vb[nacc];
                bus.cin = vc[nacc];
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        total++;
        if (nacc != 4 || nres != 4) begin
            bad++;
            $display("FAIL b2b_count: got acc=%0d res=%0d want 4 4", nacc, nres);
        end else begin
            for (int i = 1; i < 4; i++) begin
                total++;
                if (acc_cyc[i] - acc_cyc[i-1] != 10) begin
                    bad++;
                    $display("FAIL b2b_spacing%0d: got %0d want 10", i,
                             acc_cyc[i] - acc_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [33:0] expq [$];
        logic [33:0] exp;
        int issued, received, cyc, rbad;
        issued = 0;
        received = 0;
        cyc = 0;
        rbad = 0;
        while (received < N_RAND && cyc < 20000) begin
            bus.in_valid = (issued < N_RAND) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.a = $urandom;
            bus.b = $urandom;
            bus.cin = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back(golden(bus.a, bus.b, bus.cin));
                issued++;
            end
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    rbad++;
                    $display("FAIL rand_dup: got unexpected result %h want none", bus.sum);
                end else begin
                    exp = expq.pop_front();
                    if ({bus.ovf, bus.cout, bus.sum} !== exp) begin
                        bad++;
                        rbad++;
                        if (rbad < 10)
                            $display("FAIL rand_result%0d: got %h want %h", received,
                                     {bus.ovf, bus.cout, bus.sum}, exp);
                    end
                end
                received++;
            end
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        total++;
        if (issued != N_RAND || received != N_RAND || expq.size() != 0) begin
            bad++;
            $display("FAIL rand_count: got issued=%0d received=%0d pending=%0d want %0d %0d 0",
                     issued, received, expq.size(), N_RAND, N_RAND);
        end
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_overflow();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
